// File: rtl/wide_compare_sequencer.sv
// Multi-byte unsigned compare built by stepping an external 8-bit
// cascadable comparator one byte per clock, least-significant byte first.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   start, op_a, op_b      request and operands, taken when busy=0
//   busy, done             in-progress level, one-cycle result pulse
//   res_lt/eq/gt, err      held result flags, sticky non-one-hot error
//   cmp_a, cmp_b           byte pair presented to the comparator
//   cmp_lt/eq/gt_in        cascade flags presented to the comparator
//   cmp_lt/eq/gt_out       comparator outputs, captured every RUN edge
module wide_compare_sequencer #(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WORDS*8-1:0] op_a,
  input  logic [WORDS*8-1:0] op_b,
  output logic               busy,
  output logic               done,
  output logic               res_lt,
  output logic               res_eq,
  output logic               res_gt,
  output logic               err,
  output logic [7:0]         cmp_a,
  output logic [7:0]         cmp_b,
  output logic               cmp_lt_in,
  output logic               cmp_eq_in,
  output logic               cmp_gt_in,
  input  logic               cmp_lt_out,
  input  logic               cmp_eq_out,
  input  logic               cmp_gt_out
);

  localparam int W  = WORDS * 8;
  localparam int IW = $clog2(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);
  localparam logic [2:0] CASC_EQ = 3'b010;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t        r_state, w_state;
  logic [IW-1:0] r_idx, w_idx;
  logic [W-1:0]  r_a, w_a;
  logic [W-1:0]  r_b, w_b;
  logic [2:0]    r_casc, w_casc;
  logic [2:0]    r_res, w_res;
  logic          r_done, w_done;
  logic          r_err, w_err;

  logic [2:0]    w_flags;
  logic          w_onehot;
  logic [IW+2:0] w_sel;

  assign w_flags  = {cmp_lt_out, cmp_eq_out, cmp_gt_out};
  assign w_onehot = (w_flags == 3'b100) ||
                    (w_flags == 3'b010) ||
                    (w_flags == 3'b001);
  assign w_sel    = {r_idx, 3'b000};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_casc  <= CASC_EQ;
      r_res   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_idx   <= w_idx;
      r_a     <= w_a;
      r_b     <= w_b;
      r_casc  <= w_casc;
      r_res   <= w_res;
      r_done  <= w_done;
      r_err   <= w_err;
    end
  end

  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_a     = r_a;
    w_b     = r_b;
    w_casc  = r_casc;
    w_res   = r_res;
    w_done  = 1'b0;
    w_err   = r_err;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state = S_RUN;
          w_idx   = '0;
          w_a     = op_a;
          w_b     = op_b;
          w_casc  = CASC_EQ;
          w_res   = '0;
          w_err   = 1'b0;
        end
      end
      S_RUN: begin
        w_casc = w_flags;
        if (!w_onehot) w_err = 1'b1;
        if (r_idx == LAST) begin
          // results are the raw flags even when err is raised
          w_res   = w_flags;
          w_done  = 1'b1;
          w_state = S_IDLE;
          w_idx   = '0;
        end else begin
          w_idx = r_idx + IW'(1);
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_comb begin
    cmp_a = 8'h00;
    cmp_b = 8'h00;
    {cmp_lt_in, cmp_eq_in, cmp_gt_in} = CASC_EQ;
    if (r_state == S_RUN) begin
      cmp_a = r_a[w_sel +: 8];
      cmp_b = r_b[w_sel +: 8];
      {cmp_lt_in, cmp_eq_in, cmp_gt_in} = r_casc;
    end
  end

  assign busy   = (r_state == S_RUN);
  assign done   = r_done;
  assign res_lt = r_res[2];
  assign res_eq = r_res[1];
  assign res_gt = r_res[0];
  assign err    = r_err;

endmodule

// File: tb/tb_wide_compare_sequencer.sv
// Self-checking bench: behavioural 8-bit comparator around the DUT,
// expected results from whole-operand integer comparison.
module tb_wide_compare_sequencer;

  localparam int WORDS = 4;
  localparam int W = WORDS * 8;

  logic         clk = 0;
  logic         rst_n = 0;
  logic         start = 0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         busy, done, res_lt, res_eq, res_gt, err;
  logic [7:0]   cmp_a, cmp_b;
  logic         cmp_lt_in, cmp_eq_in, cmp_gt_in;
  logic         m_lt, m_eq, m_gt;
  logic         inj = 0;

  int checks = 0;
  int errors = 0;

  logic [7:0] seen_a [16];
  int         run_cyc;
  int         run_busy;

  wide_compare_sequencer #(.WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done),
    .res_lt(res_lt), .res_eq(res_eq), .res_gt(res_gt),
    .err(err),
    .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_lt_in(cmp_lt_in), .cmp_eq_in(cmp_eq_in),
    .cmp_gt_in(cmp_gt_in),
    .cmp_lt_out(m_lt), .cmp_eq_out(m_eq), .cmp_gt_out(m_gt)
  );

  always #5 clk = ~clk;

  // cascadable byte comparator; inj forces an illegal LT+GT answer
  always_comb begin
    {m_lt, m_eq, m_gt} = {cmp_lt_in, cmp_eq_in, cmp_gt_in};
    if (inj) {m_lt, m_eq, m_gt} = 3'b101;
    else if (cmp_a > cmp_b) {m_lt, m_eq, m_gt} = 3'b001;
    else if (cmp_a < cmp_b) {m_lt, m_eq, m_gt} = 3'b100;
  end

  function automatic logic [2:0] ref_cmp(logic [W-1:0] a,
                                         logic [W-1:0] b);
    if (a < b) return 3'b100;
    if (a > b) return 3'b001;
    return 3'b010;
  endfunction

  // stimulus only: called at #1 after an edge; returns there after done
  task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int inj_byte);
    start = 1; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 0;
    run_cyc = 0;
    run_busy = 0;
    while (!done && run_cyc < 50) begin
      if (run_cyc < 16) seen_a[run_cyc] = cmp_a;
      if (busy) run_busy++;
      inj = (run_cyc == inj_byte);
      @(posedge clk); #1;
      inj = 0;
      run_cyc++;
    end
    if (!done) run_cyc = -1;
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, res_lt, res_eq, res_gt, err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outs got %b want 000000",
               {busy, done, res_lt, res_eq, res_gt, err});
    end
    checks++;
    if ({cmp_a, cmp_b, cmp_lt_in, cmp_eq_in, cmp_gt_in}
        !== {16'h0, 3'b010}) begin
      errors++;
      $display("FAIL reset_cmp got %h %h %b want 00 00 010",
               cmp_a, cmp_b, {cmp_lt_in, cmp_eq_in, cmp_gt_in});
    end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero;
    run_cmp('0, '0, -1);
    checks++;
    if (run_cyc !== WORDS || run_busy !== WORDS) begin
      errors++;
      $display("FAIL zero_latency got cyc=%0d busy=%0d want %0d",
               run_cyc, run_busy, WORDS);
    end
    checks++;
    if ({res_lt, res_eq, res_gt, err, busy} !== 5'b01000) begin
      errors++;
      $display("FAIL zero_res got %b want 01000",
               {res_lt, res_eq, res_gt, err, busy});
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || res_eq !== 1'b1) begin
      errors++;
      $display("FAIL zero_pulse got done=%b eq=%b want 0 1",
               done, res_eq);
    end
  endtask

  task automatic test_msb_dominates;
    logic [7:0] exp_seq [4];
    exp_seq[0] = 8'h01; exp_seq[1] = 8'h00;
    exp_seq[2] = 8'h00; exp_seq[3] = 8'hC0;
    run_cmp(32'hC000_0001, 32'h4000_00FF, -1);
    checks++;
    if ({res_lt, res_eq, res_gt} !== 3'b001 || run_cyc !== WORDS) begin
      errors++;
      $display("FAIL msb_res got %b cyc=%0d want 001 cyc=%0d",
               {res_lt, res_eq, res_gt}, run_cyc, WORDS);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (seen_a[k] !== exp_seq[k]) begin
        errors++;
        $display("FAIL msb_cmp_a[%0d] got %h want %h",
                 k, seen_a[k], exp_seq[k]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_busy;
    int cyc;
    start = 1; op_a = 32'h1234_5670; op_b = 32'h1234_5680;
    @(posedge clk); #1;
    start = 1; op_a = 32'hFFFF_FFFF; op_b = 32'h0;
    @(posedge clk); #1;
    start = 0;
    cyc = 1;
    while (!done && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if ({res_lt, res_eq, res_gt} !== 3'b100 || cyc !== WORDS) begin
      errors++;
      $display("FAIL ignore_res got %b cyc=%0d want 100 cyc=%0d",
               {res_lt, res_eq, res_gt}, cyc, WORDS);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({res_lt, res_eq, res_gt, busy, done} !== 5'b10000) begin
      errors++;
      $display("FAIL ignore_hold got %b want 10000",
               {res_lt, res_eq, res_gt, busy, done});
    end
  endtask

  task automatic test_back_to_back;
    time t1, t2;
    run_cmp(32'h1, 32'h2, -1);
    t1 = $time;
    run_cmp(32'hFF00_0000, 32'hF000_0000, -1);
    t2 = $time;
    checks++;
    if (run_cyc < 0 || (t2 - t1) !== 50) begin
      errors++;
      $display("FAIL b2b_gap got %0t want 50", t2 - t1);
    end
    checks++;
    if ({res_lt, res_eq, res_gt, err} !== 4'b0010) begin
      errors++;
      $display("FAIL b2b_res got %b want 0010",
               {res_lt, res_eq, res_gt, err});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fault;
    run_cmp(32'h1122_3344, 32'h1022_3344, 2);
    checks++;
    if (err !== 1'b1 || res_gt !== 1'b1 || run_cyc !== WORDS) begin
      errors++;
      $display("FAIL fault_err got err=%b gt=%b cyc=%0d want 1 1 %0d",
               err, res_gt, run_cyc, WORDS);
    end
    start = 1; op_a = 32'h5; op_b = 32'h5;
    @(posedge clk); #1;
    start = 0;
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fault_clear got err=%b busy=%b want 0 1", err, busy);
    end
    while (busy) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset;
    int seen_done;
    start = 1; op_a = 32'h0000_0009; op_b = 32'h0000_0003;
    @(posedge clk); #1;
    start = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    checks++;
    if ({busy, done, res_lt, res_eq, res_gt, err} !== 6'b0 ||
        {cmp_lt_in, cmp_eq_in, cmp_gt_in} !== 3'b010) begin
      errors++;
      $display("FAIL midrst got %b casc=%b want 000000 010",
               {busy, done, res_lt, res_eq, res_gt, err},
               {cmp_lt_in, cmp_eq_in, cmp_gt_in});
    end
    seen_done = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    checks++;
    if (seen_done !== 0) begin
      errors++;
      $display("FAIL midrst_nodone got %0d want 0", seen_done);
    end
    run_cmp(32'h0000_0009, 32'h0000_0003, -1);
    checks++;
    if ({res_lt, res_eq, res_gt} !== 3'b001 || run_cyc !== WORDS) begin
      errors++;
      $display("FAIL midrst_after got %b want 001",
               {res_lt, res_eq, res_gt});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic [W-1:0] a, b;
    logic [2:0]   exp;
    for (int n = 0; n < 24; n++) begin
      a = $urandom;
      b = $urandom;
      for (int k = 0; k < WORDS; k++)
        if ($urandom_range(0, 1) == 1) b[8*k +: 8] = a[8*k +: 8];
      if (n % 8 == 0) b = a;
      exp = ref_cmp(a, b);
      run_cmp(a, b, -1);
      checks++;
      if ({res_lt, res_eq, res_gt} !== exp || err !== 1'b0 ||
          run_cyc !== WORDS) begin
        errors++;
        $display("FAIL rand[%0d] a=%h b=%h got %b err=%b want %b",
                 n, a, b, {res_lt, res_eq, res_gt}, err, exp);
      end
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset;
    test_zero;
    test_msb_dominates;
    test_ignore_busy;
    test_back_to_back;
    test_fault;
    test_mid_reset;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wide_compare_sequencer.md
Name: wide_compare_sequencer

Overview:
- Multi-cycle controller that compares two WORDS*8-bit unsigned operands by stepping the existing 8-bit cascadable magnitude comparator one byte per clock, least-significant byte first.
- Sits directly around the comparator:
  - upstream: it drives the comparator's A, B and LT_IN/EQ_IN/GT_IN;
  - downstream: it registers the comparator's LT_OUT/EQ_OUT/GT_OUT and feeds them back as the next byte's cascade inputs.
- Presents a start/busy/done handshake and a held three-way result to the datapath.

Parameters:
- WORDS, 4, number of 8-bit slices per operand; operand width is WORDS*8; legal range 2..16.

Ports:
- clk  input  1  single system clock, all state on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- start  input  1  request a comparison; accepted only when busy=0.
- op_a  input  WORDS*8  operand A, sampled on the accepting edge.
- op_b  input  WORDS*8  operand B, sampled on the accepting edge.
- busy  output  1  high while a comparison is in progress.
- done  output  1  one-cycle pulse when a result becomes valid.
- res_lt  output  1  A<B, held until the next accepted start.
- res_eq  output  1  A==B, held.
- res_gt  output  1  A>B, held.
- err  output  1  comparator returned a non-one-hot flag set during this comparison; held.
- cmp_a  output  8  byte of A presented to the comparator.
- cmp_b  output  8  byte of B presented to the comparator.
- cmp_lt_in  output  1  cascade LT into the comparator.
- cmp_eq_in  output  1  cascade EQ into the comparator.
- cmp_gt_in  output  1  cascade GT into the comparator.
- cmp_lt_out  input  1  comparator LT_OUT (combinational from cmp_* outputs).
- cmp_eq_out  input  1  comparator EQ_OUT.
- cmp_gt_out  input  1  comparator GT_OUT.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE; busy=0, done=0, res_lt=0, res_eq=0, res_gt=0, err=0.
  - Byte index=0; cascade register = {lt,eq,gt}={0,1,0}; operand registers cleared.
- Reset mid-comparison: aborts immediately. No done pulse. Results stay at reset values.
- States:
  - IDLE -> RUN on an edge with start=1 and busy=0.
    - Latch op_a/op_b, index=0, cascade reg={0,1,0}, clear err, busy=1.
    - Previous res_* are cleared to 0 on acceptance.
  - RUN, each edge:
    - Capture {cmp_lt_out,cmp_eq_out,cmp_gt_out} into the cascade reg.
    - If the captured flags are not exactly one-hot, set err (sticky for this comparison).
    - If index==WORDS-1: load res_* from the captured flags, done=1, busy=0, go to IDLE.
    - Else index+1.
- Comparator drive (combinational from registers):
  - In RUN: cmp_a = latched A byte[index], cmp_b = latched B byte[index], cmp_*_in = cascade reg.
  - In IDLE: cmp_a=cmp_b=0, cascade={0,1,0}.
- Latency:
  - Start accepted at edge E0; RUN occupies edges E1..E(WORDS).
  - done=1 and res_* valid after E(WORDS); busy high from after E0 until after E(WORDS), i.e. exactly WORDS cycles.
- done is high for exactly one cycle, deasserted at the next edge unless re-armed.
- Start is ignored while busy=1: no effect on state, operands or results.
- Start during the done cycle is accepted (busy=0 there), giving back-to-back comparisons every WORDS+1 cycles.
  - In that case the res_* clear and done deassertion happen on the same edge.
- Arithmetic: unsigned magnitude. Byte k occupies bits [8k+7:8k]. Higher-index byte dominates via cascade.
- err does not alter res_*: results are the raw captured flags.

Test Plan:
- WORDS=4, A=0x0000_0000, B=0x0000_0000, start 1 cycle -> busy 4 cycles, done pulse, res_eq=1, res_lt=res_gt=0, err=0.
- A=0xC000_0001, B=0x4000_00FF -> res_gt=1 (MSB byte dominates despite LSB A<B); cmp_a sequence 0x01,0x00,0x00,0xC0.
- A=0x1234_5670, B=0x1234_5680 -> res_lt=1; second start raised while busy is ignored; results hold until the next accepted start.
- Back-to-back: start in the done cycle with A=0xFF00_0000, B=0xF000_0000 -> second done exactly 5 cycles after the first, res_gt=1.
- Comparator model forced to return LT=1,GT=1 on byte 2 -> err=1 at done, cleared by the next accepted start.
- rst_n=0 for one edge at RUN index 2 -> busy=0, no done pulse, res_*=0, cmp cascade={0,1,0}; a new start afterwards completes normally.
